fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised next-generation fetch stage: issues PCs to a synchronous imem and buffers returned instructions with their PCs in a DEPTH-entry queue. Decode drains the queue through a valid/ready handshake.
- Handles jump redirects (flushes the queue and the in-flight request) and vectored interrupts (saves a restart PC, redirects to a vector).
- Sits between the PC/imem and the F/D boundary. It replaces stall-by-freezing-PC with backpressure.

Parameters:
- PC_WIDTH, 32: width of all PC/address signals
- INSN_WIDTH, 32: instruction width
- DEPTH, 4: queue entries; power of 2, ≥2
- RESET_PC, 0: PC after reset
- IRQ_VECTOR, 1: PC loaded when an interrupt is taken

Ports:
- clock  in  1  master clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- address_imem  out  PC_WIDTH  fetch address (current PC)
- imem_req  out  1  address_imem valid this cycle
- q_imem  in  INSN_WIDTH  imem data for the address issued in the previous cycle
- should_jump  in  1  redirect request (from execute)
- jump_to  in  PC_WIDTH  redirect target
- irq_request  in  1  level interrupt request
- irq_ack  out  1  one-cycle pulse, interrupt taken
- epc  out  PC_WIDTH  restart PC captured at interrupt
- dec_valid  out  1  queue head valid to decode
- dec_ready  in  1  decode accepts head
- dec_instruction  out  INSN_WIDTH  head instruction
- dec_pc  out  PC_WIDTH  head PC
- dec_incremented_pc  out  PC_WIDTH  head PC+1
- queue_count  out  clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (async):
  - PC=RESET_PC; queue empty; in-flight cleared.
  - epc=0; irq_ack=0; irq armed.
  - Resulting outputs: dec_valid=0, imem_req=0, queue_count=0.
- pop = dec_valid & dec_ready.
  - Head outputs are driven combinationally from the queue head.
  - Head outputs hold stable while dec_valid=1 and dec_ready=0.
- Issue: imem_req=1 when no flush/irq this cycle and count + inflight − pop < DEPTH.
  - On issue: PC ← PC+1 (modulo 2^PC_WIDTH); inflight ← 1; inflight_pc ← PC.
  - Otherwise inflight ← 0 and PC holds.
- Return:
  - If inflight=1, q_imem is pushed at the edge with inflight_pc.
  - Push and pop in the same cycle are both applied; count is unchanged.
  - The issue rule guarantees a push never overflows.
- Latency and throughput:
  - Issue in cycle N → data in cycle N+1 → dec_valid in cycle N+2.
  - Sustains 1 instruction/cycle with dec_ready=1 for any DEPTH ≥ 2.
- Pointers: read and write pointers are log2(DEPTH) bits wide and wrap naturally.
- Jump (should_jump=1), in that cycle:
  - dec_valid forced 0, so no pop; imem_req=0.
  - At the edge: queue emptied, in-flight discarded (returned data is not pushed), PC ← jump_to.
  - jump_to is issued next cycle; target reaches dec_valid 3 cycles after the jump cycle.
- Interrupt taken when irq_request=1, irq armed and should_jump=0. In that cycle:
  - dec_valid=0 and imem_req=0.
  - At the edge, epc ← restart point, chosen in priority order:
    - head PC if count>0;
    - else inflight_pc if inflight=1;
    - else current PC.
  - At the same edge: flush as for a jump; PC ← IRQ_VECTOR; irq_ack=1 for the next cycle; irq disarmed.
  - irq re-arms when irq_request=0.
- Simultaneous jump and irq:
  - Jump wins; irq stays pending and is taken next cycle (if still requested).
  - In that case epc = jump_to.
- Reset asserted mid-operation returns everything to reset values immediately; any in-flight imem data is ignored.

Test Plan:
- Reset release, dec_ready=1, imem returns q_imem = address+0x100:
  - address_imem 0,1,2… on consecutive cycles;
  - dec_pc=0 with instruction 0x100 two cycles after first issue;
  - thereafter one instruction per cycle; dec_incremented_pc = dec_pc+1.
- dec_ready=0 for 10 cycles:
  - queue_count saturates at 4; imem_req drops;
  - head stays PC 0 and data stable;
  - on release, PCs 0..5 delivered in order with no gaps or duplicates.
- should_jump=1, jump_to=0x40, asserted with 3 entries queued and 1 in flight:
  - queue_count=0 next cycle; stale data discarded;
  - address_imem=0x40 next cycle; dec_pc=0x40 three cycles after the jump.
- irq_request high with queue head PC 7:
  - epc=7; irq_ack pulses once; address_imem=IRQ_VECTOR;
  - holding irq_request high gives no second ack until it drops and rises again.
- Simultaneous should_jump (jump_to=0x20) and irq_request:
  - jump first; irq taken next cycle with epc=0x20.
- PC at 0xFFFFFFFF issues:
  - wraps to 0;
  - reset pulsed mid-stream clears queue_count and dec_valid asynchronously, and fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch-stage bundle: imem request/return, redirect and interrupt controls, and the decode handshake.
// The master modport is the fetch_queue side; slave is the surrounding pipeline/imem.
interface fetch_queue_if #(
  parameter int PC_WIDTH   = 32,
  parameter int INSN_WIDTH = 32,
  parameter int DEPTH      = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PC_WIDTH-1:0]   address_imem;
  logic                  imem_req;
  logic [INSN_WIDTH-1:0] q_imem;
  logic                  should_jump;
  logic [PC_WIDTH-1:0]   jump_to;
  logic                  irq_request;
  logic                  irq_ack;
  logic [PC_WIDTH-1:0]   epc;
  logic                  dec_valid;
  logic                  dec_ready;
  logic [INSN_WIDTH-1:0] dec_instruction;
  logic [PC_WIDTH-1:0]   dec_pc;
  logic [PC_WIDTH-1:0]   dec_incremented_pc;
  logic [CW-1:0]         queue_count;

  modport master (
    output address_imem, imem_req,
    input  q_imem,
    input  should_jump, jump_to, irq_request,
    output irq_ack, epc,
    output dec_valid, dec_instruction, dec_pc, dec_incremented_pc, queue_count,
    input  dec_ready
  );

  modport slave (
    input  address_imem, imem_req,
    output q_imem,
    output should_jump, jump_to, irq_request,
    input  irq_ack, epc,
    input  dec_valid, dec_instruction, dec_pc, dec_incremented_pc, queue_count,
    output dec_ready
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch stage: issues PCs to a 1-cycle imem and queues returned instructions for decode (valid/ready).
// Issue-to-dec_valid latency 2 cycles; backpressure throttles issue so the queue can never overflow.
module fetch_queue #(
  parameter int                     PC_WIDTH   = 32,
  parameter int                     INSN_WIDTH = 32,
  parameter int                     DEPTH      = 4,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0,
  parameter logic [PC_WIDTH-1:0]    IRQ_VECTOR = {{(PC_WIDTH-1){1'b0}}, 1'b1}
) (
  input logic            clock,
  input logic            reset,
  fetch_queue_if.master  fq
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int OW = CW + 1;

  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  inflight_q, inflight_d;
  logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PC_WIDTH-1:0]   epc_q, epc_d;
  logic                  irq_ack_q, irq_ack_d;
  logic                  armed_q, armed_d;
  logic [INSN_WIDTH-1:0] insn_mem_q [DEPTH];
  logic [PC_WIDTH-1:0]   pc_mem_q   [DEPTH];

  logic                  irq_take, flush, dec_valid, pop, push, issue;
  logic [OW-1:0]         occupancy;
  logic [PC_WIDTH-1:0]   restart_pc;

  always_comb begin
    irq_take  = fq.irq_request & armed_q & ~fq.should_jump;
    flush     = fq.should_jump | irq_take;
    dec_valid = (count_q != '0) & ~flush;
    pop       = dec_valid & fq.dec_ready;
    push      = inflight_q & ~flush;
    // Occupancy after this cycle's pop plus the request already in flight.
    occupancy = {1'b0, count_q} + OW'(inflight_q) - OW'(pop);
    issue     = ~flush & ~reset & (occupancy < OW'(DEPTH));
  end

  always_comb begin
    restart_pc = pc_q;
    if (count_q != '0)   restart_pc = pc_mem_q[rd_ptr_q];
    else if (inflight_q) restart_pc = inflight_pc_q;
  end

  always_comb begin
    pc_d          = pc_q;
    inflight_d    = issue;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q + CW'(push) - CW'(pop);
    rd_ptr_d      = rd_ptr_q + AW'(pop);
    wr_ptr_d      = wr_ptr_q + AW'(push);
    epc_d         = epc_q;
    irq_ack_d     = irq_take;
    armed_d       = armed_q;

    if (fq.should_jump) begin
      pc_d = fq.jump_to;
    end else if (irq_take) begin
      pc_d  = IRQ_VECTOR;
      epc_d = restart_pc;
    end else if (issue) begin
      pc_d          = pc_q + PC_WIDTH'(1);
      inflight_pc_d = pc_q;
    end

    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end

    if (irq_take)             armed_d = 1'b0;
    else if (!fq.irq_request) armed_d = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      epc_q         <= '0;
      irq_ack_q     <= 1'b0;
      armed_q       <= 1'b1;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      epc_q         <= epc_d;
      irq_ack_q     <= irq_ack_d;
      armed_q       <= armed_d;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        insn_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else if (push) begin
      insn_mem_q[wr_ptr_q] <= fq.q_imem;
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
    end
  end

  assign fq.address_imem       = pc_q;
  assign fq.imem_req           = issue;
  assign fq.irq_ack            = irq_ack_q;
  assign fq.epc                = epc_q;
  assign fq.dec_valid          = dec_valid;
  assign fq.dec_instruction    = insn_mem_q[rd_ptr_q];
  assign fq.dec_pc             = pc_mem_q[rd_ptr_q];
  assign fq.dec_incremented_pc = pc_mem_q[rd_ptr_q] + PC_WIDTH'(1);
  assign fq.queue_count        = count_q;
endmodule
